// File: rtl/mem_arb_pkg.sv
// Shared encodings for the main-memory port arbiter, its cache controllers and monitors.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/arb_lat_counter.sv
// Access sequencer: counts the BUSY cycles of one access, flagging the strobe cycle and
// the cycle whose memory data is captured.
module arb_lat_counter #(
  parameter int MEM_LAT = 4,
  parameter int CW      = $clog2(MEM_LAT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic first,
  output logic capture
);

  localparam logic [CW-1:0] LAT_MAX = CW'(MEM_LAT);

  logic [CW-1:0] lat_cnt;

  // Parks at LAT_MAX until the FSM leaves BUSY, so it can never wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_cnt <= '0;
    end else if (load || !run) begin
      lat_cnt <= '0;
    end else if (lat_cnt != LAT_MAX) begin
      lat_cnt <= lat_cnt + CW'(1);
    end
  end

  assign first   = run && (lat_cnt == '0);
  assign capture = run && (lat_cnt == LAT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between I-fill and D-fill/writeback: D priority with an
// I starvation guard, one fixed-latency access per MEM_LAT+3 cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_grant,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_grant,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          arb_busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  arb_state_t    state, state_nxt;
  logic          grant_i, grant_d;
  logic          owner, wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] streak;
  logic          busy_st, strobe, capture;

  assign busy_st = (state == BUSY_I) || (state == BUSY_D);

  arb_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk     (clk),
    .rst     (rst),
    .load    (grant_i || grant_d),
    .run     (busy_st),
    .first   (strobe),
    .capture (capture)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Grants are gated by reset so nothing is accepted in the cycle being reset.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (rst) begin
          if (d_req && !(i_req && (streak == STREAK_MAX))) begin
            grant_d   = 1'b1;
            state_nxt = BUSY_D;
          end else if (i_req) begin
            grant_i   = 1'b1;
            state_nxt = BUSY_I;
          end
        end
      end
      BUSY_I, BUSY_D: if (capture) state_nxt = DONE;
      DONE:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner   <= OWNER_I;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_d) begin
      owner   <= OWNER_D;
      wr_q    <= d_wr;
      addr_q  <= d_addr;
      wdata_q <= d_wdata;
    end else if (grant_i) begin
      owner   <= OWNER_I;
      wr_q    <= 1'b0;
      addr_q  <= i_addr;
      wdata_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      streak <= '0;
    end else if (grant_i || (grant_d && !i_req)) begin
      streak <= '0;
    end else if (grant_d && (streak != STREAK_MAX)) begin
      streak <= streak + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if (capture) begin
      if (owner == OWNER_I)  i_rdata <= mem_rdata;
      else if (!wr_q)        d_rdata <= mem_rdata;
    end
  end

  assign i_grant   = grant_i;
  assign d_grant   = grant_d;
  assign i_done    = (state == DONE) && (owner == OWNER_I);
  assign d_done    = (state == DONE) && (owner == OWNER_D);
  assign mem_en    = strobe;
  assign mem_wr    = strobe && wr_q;
  assign mem_addr  = strobe ? addr_q  : '0;
  assign mem_wdata = strobe ? wdata_q : '0;
  assign arb_busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model,
// plus a directed MEM_LAT=1 read on a second instance.
module tb_mem_port_arbiter;

  localparam int LAT  = 4;
  localparam int SMAX = 3;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_grant, i_done, d_grant, d_done, mem_en, mem_wr, arb_busy;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  logic        d1_req, d1_wr;
  logic [15:0] d1_addr, d1_wdata, m1_rdata;
  logic        i1_grant, i1_done, d1_grant, d1_done, m1_en, m1_wr, busy1;
  logic [15:0] i1_rdata, d1_rdata, m1_addr, m1_wdata;

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .arb_busy(arb_busy)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .i_req(1'b0), .i_addr(16'h0000), .i_grant(i1_grant), .i_done(i1_done), .i_rdata(i1_rdata),
    .d_req(d1_req), .d_wr(d1_wr), .d_addr(d1_addr), .d_wdata(d1_wdata),
    .d_grant(d1_grant), .d_done(d1_done), .d_rdata(d1_rdata),
    .mem_en(m1_en), .mem_wr(m1_wr), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .arb_busy(busy1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Environment memory (reacts to the DUT bus) and the model's own view of memory.
  logic [15:0] env_mem [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];
  int          ret_cyc [$];
  logic [15:0] ret_dat [$];

  // Reference model state: at most one access in flight, described by its milestones.
  bit          act, i_pend, d_pend, rst_done;
  int          men_cyc, done_cyc, streak, p_i, p_d, junk;
  logic        m_owner, m_wr;
  logic [15:0] m_addr, m_wdata, m_rd, e_i_rdata, e_d_rdata;
  logic        e_ig, e_dg, e_id, e_dd, e_men, e_busy;

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    d1_req = 1'b0; d1_wr = 1'b0; d1_addr = '0; d1_wdata = '0; m1_rdata = '0;
    repeat (3) step();
    @(negedge clk);
    check("rst_busy", arb_busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_grants", {i_grant, d_grant, i_done, d_done}, 0);
    check("rst_lat1_busy", busy1, 0);

    // Directed read on the MEM_LAT=1 instance.
    step(); rst = 1'b1;
    step(); d1_req = 1'b1; d1_wr = 1'b0; d1_addr = 16'h0042; m1_rdata = 16'h1111;
    @(negedge clk);
    check("lat1_grant", d1_grant, 1);
    check("lat1_no_early_en", m1_en, 0);
    step();
    @(negedge clk);
    check("lat1_mem_en", m1_en, 1);
    check("lat1_mem_addr", m1_addr, 16'h0042);
    check("lat1_mem_wr", m1_wr, 0);
    step(); m1_rdata = 16'hA5A5;
    @(negedge clk);
    check("lat1_not_done_yet", d1_done, 0);
    check("lat1_en_once", m1_en, 0);
    step(); m1_rdata = 16'h2222;
    @(negedge clk);
    check("lat1_done", d1_done, 1);
    check("lat1_rdata", d1_rdata, 16'hA5A5);
    step(); d1_req = 1'b0;
    @(negedge clk);
    check("lat1_idle", busy1, 0);
    check("lat1_rdata_hold", d1_rdata, 16'hA5A5);
    check("lat1_i_quiet", {i1_grant, i1_done, i1_rdata}, 0);

    // Randomized traffic on the MEM_LAT=4 instance.
    act = 0; i_pend = 0; d_pend = 0; rst_done = 0; streak = 0;
    e_i_rdata = '0; e_d_rdata = '0; m_rd = '0;
    for (int n = 0; n < NCYC; n++) begin
      step();
      if (n < 1000)      begin p_i = 30; p_d = 30; end
      else if (n < 2000) begin p_i = 70; p_d = 95; end
      else               begin p_i = 80; p_d = 25; end

      rst = 1'b1;
      if (!rst_done && n > 1500 && act && cyc == men_cyc + 2) begin
        rst = 1'b0;
        rst_done = 1;
      end
      if (!i_pend) begin
        if ($urandom_range(0, 99) < p_i) begin
          i_pend = 1; i_req = 1'b1; i_addr = 16'($urandom_range(0, 15));
        end else begin
          i_req = 1'b0; i_addr = 16'($urandom);
        end
      end
      if (!d_pend) begin
        if ($urandom_range(0, 99) < p_d) begin
          d_pend = 1; d_req = 1'b1; d_wr = 1'($urandom_range(0, 1));
          d_addr = 16'($urandom_range(0, 15)); d_wdata = 16'($urandom);
        end else begin
          d_req = 1'b0; d_wr = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
        end
      end
      mem_rdata = 16'($urandom);
      if (ret_cyc.size() > 0 && ret_cyc[0] == cyc) begin
        mem_rdata = ret_dat.pop_front();
        junk = ret_cyc.pop_front();
      end

      @(negedge clk);
      if (!rst) begin
        act = 0; streak = 0; i_pend = 0; d_pend = 0;
        e_i_rdata = '0; e_d_rdata = '0;
      end else begin
        e_ig = 0; e_dg = 0; e_id = 0; e_dd = 0; e_men = 0;
        e_busy = act;
        if (!act) begin
          if (d_req && !(i_req && streak == SMAX)) begin
            e_dg = 1; act = 1; m_owner = 1; m_wr = d_wr; m_addr = d_addr; m_wdata = d_wdata;
            streak = i_req ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
          end else if (i_req) begin
            e_ig = 1; act = 1; m_owner = 0; m_wr = 0; m_addr = i_addr; m_wdata = '0;
            streak = 0;
          end
          if (act) begin
            men_cyc  = cyc + 1;
            done_cyc = cyc + LAT + 2;
          end
        end else begin
          if (cyc == men_cyc) begin
            e_men = 1;
            if (m_wr) ref_mem[m_addr] = m_wdata;
            else m_rd = ref_mem.exists(m_addr) ? ref_mem[m_addr] : init_val(m_addr);
          end
          if (cyc == done_cyc) begin
            act = 0;
            if (m_owner) begin
              e_dd = 1; d_pend = 0;
              if (!m_wr) e_d_rdata = m_rd;
            end else begin
              e_id = 1; i_pend = 0; e_i_rdata = m_rd;
            end
          end
        end
        check("i_grant", i_grant, e_ig);
        check("d_grant", d_grant, e_dg);
        check("i_done", i_done, e_id);
        check("d_done", d_done, e_dd);
        check("mem_en", mem_en, e_men);
        check("arb_busy", arb_busy, e_busy);
        check("i_rdata", i_rdata, e_i_rdata);
        check("d_rdata", d_rdata, e_d_rdata);
        if (e_men) begin
          check("mem_wr", mem_wr, m_wr);
          check("mem_addr", mem_addr, m_addr);
          check("mem_wdata", mem_wdata, m_wdata);
        end
      end

      if (mem_en) begin
        if (mem_wr) begin
          if (rst) env_mem[mem_addr] = mem_wdata;
        end else begin
          ret_cyc.push_back(cyc + LAT);
          ret_dat.push_back(env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_val(mem_addr));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
